// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single memory port (IDLE/BUSY/RESP FSM).
// Optional BUSY watchdog enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        s_req,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        grant_m1;
    logic        ack_now;
    logic        timeout_hit;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    logic [7:0]  timer;
    logic        err_q;
`endif

    assign s_write = cmd_write;
    assign s_addr  = cmd_addr;
    assign s_wdata = cmd_wdata;

    // M1 wins when it is the only requester, or on a tie when M0 was granted last.
    always_comb begin
        grant_m1    = m1_req && (!m0_req || !last_grant);
        ack_now     = (state == BUSY) && s_ack;
        timeout_hit = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        timeout_hit = (state == BUSY) && !s_ack && (timer == 8'(TIMEOUT_CYCLES - 1));
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            s_req      <= 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            timer      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= grant_m1;
                        last_grant <= grant_m1;
                        cmd_write  <= grant_m1 ? m1_write : m0_write;
                        cmd_addr   <= grant_m1 ? m1_addr  : m0_addr;
                        cmd_wdata  <= grant_m1 ? m1_wdata : m0_wdata;
                        s_req      <= 1'b1;
                        state      <= BUSY;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                        timer      <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Writes never touch rdata on a normal completion.
                    if (ack_now && !cmd_write) begin
                        if (owner) m1_rdata <= s_rdata;
                        else       m0_rdata <= s_rdata;
                    end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    if (timeout_hit) begin
                        if (owner) m1_rdata <= 32'hDEAD_BEEF;
                        else       m0_rdata <= 32'hDEAD_BEEF;
                        err_q <= 1'b1;
                    end else if (!s_ack) begin
                        timer <= timer + 8'd1;
                    end
`endif
                    if (ack_now || timeout_hit) begin
                        s_req  <= 1'b0;
                        m0_ack <= ~owner;
                        m1_ack <= owner;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; timeout behaviour depends on MEM_BUS_ARBITER_TIMEOUT_EN.
module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        s_req, s_write, s_ack, err;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_req(s_req), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .err(err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
        s_ack = 0; s_rdata = 0;
        step();
        step();
        check("rst_s_req", {31'd0, s_req}, 32'd0);
        check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        check("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        reset = 1'b0;

        // Single zero-wait read from M0
        m0_req = 1; m0_write = 0; m0_addr = 32'h100;
        step();
        check("rd_busy_s_req", {31'd0, s_req}, 32'd1);
        check("rd_busy_s_addr", s_addr, 32'h100);
        check("rd_busy_s_write", {31'd0, s_write}, 32'd0);
        check("rd_busy_m0_ack", {31'd0, m0_ack}, 32'd0);
        s_ack = 1; s_rdata = 32'h1234_5678;
        step();
        check("rd_resp_m0_ack", {31'd0, m0_ack}, 32'd1);
        check("rd_resp_m1_ack", {31'd0, m1_ack}, 32'd0);
        check("rd_resp_m0_rdata", m0_rdata, 32'h1234_5678);
        check("rd_resp_s_req", {31'd0, s_req}, 32'd0);
        m0_req = 0; s_ack = 0;
        step();
        check("rd_idle_m0_ack", {31'd0, m0_ack}, 32'd0);

        // Spurious s_ack while idle
        s_ack = 1; s_rdata = 32'hFFFF_FFFF;
        step();
        step();
        check("spur_m0_ack", {31'd0, m0_ack}, 32'd0);
        check("spur_m1_ack", {31'd0, m1_ack}, 32'd0);
        check("spur_s_req", {31'd0, s_req}, 32'd0);
        check("spur_m0_rdata", m0_rdata, 32'h1234_5678);
        s_ack = 0;

        // M1 write with five wait states
        m1_req = 1; m1_write = 1; m1_addr = 32'h200; m1_wdata = 32'hCAFE_F00D;
        s_rdata = 32'h5555_5555;
        step();
        check("wr_s_addr", s_addr, 32'h200);
        check("wr_s_write", {31'd0, s_write}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("wr_busy_s_req", {31'd0, s_req}, 32'd1);
            check("wr_busy_s_wdata", s_wdata, 32'hCAFE_F00D);
            check("wr_busy_m1_ack", {31'd0, m1_ack}, 32'd0);
            if (i == 5) s_ack = 1;
            step();
        end
        check("wr_resp_m1_ack", {31'd0, m1_ack}, 32'd1);
        check("wr_resp_m0_ack", {31'd0, m0_ack}, 32'd0);
        check("wr_resp_s_req", {31'd0, s_req}, 32'd0);
        check("wr_m1_rdata", m1_rdata, 32'd0);
        m1_req = 0; m1_write = 0; s_ack = 0;
        step();
        check("wr_idle_m1_ack", {31'd0, m1_ack}, 32'd0);

        // Both masters request continuously from reset: M0, M1, M0, M1
        reset = 1;
        step();
        reset = 0;
        m0_addr = 32'h10; m1_addr = 32'h20;
        m0_req = 1; m1_req = 1; s_ack = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_s_addr", s_addr, (k % 2 == 1) ? 32'h20 : 32'h10);
            check("rr_s_req", {31'd0, s_req}, 32'd1);
            s_rdata = 32'hA000_0000 + k;
            step();
            check("rr_m0_ack", {31'd0, m0_ack}, (k % 2 == 1) ? 32'd0 : 32'd1);
            check("rr_m1_ack", {31'd0, m1_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            check("rr_idle_m0_ack", {31'd0, m0_ack}, 32'd0);
            check("rr_idle_m1_ack", {31'd0, m1_ack}, 32'd0);
        end
        check("rr_m0_rdata", m0_rdata, 32'hA000_0002);
        check("rr_m1_rdata", m1_rdata, 32'hA000_0003);
        m0_req = 0; m1_req = 0; s_ack = 0;
        step();

        // Reset asserted in the middle of BUSY
        m0_req = 1; m0_addr = 32'h300;
        step();
        check("rstb_busy_s_req", {31'd0, s_req}, 32'd1);
        #2;
        reset = 1; m0_req = 0;
        #1;
        check("rstb_async_s_req", {31'd0, s_req}, 32'd0);
        check("rstb_m0_rdata", m0_rdata, 32'd0);
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstb_no_m0_ack", {31'd0, m0_ack}, 32'd0);
            check("rstb_no_s_req", {31'd0, s_req}, 32'd0);
        end
        m1_req = 1; m1_addr = 32'h400; s_ack = 1; s_rdata = 32'h0BAD_CAFE;
        step();
        check("rstb_next_s_addr", s_addr, 32'h400);
        step();
        check("rstb_next_m1_ack", {31'd0, m1_ack}, 32'd1);
        check("rstb_next_m1_rdata", m1_rdata, 32'h0BAD_CAFE);
        m1_req = 0; s_ack = 0;
        step();

        // Memory never acknowledges an M0 read
        m0_req = 1; m0_addr = 32'h500; m0_write = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("to_busy_s_req", {31'd0, s_req}, 32'd1);
            check("to_busy_m0_ack", {31'd0, m0_ack}, 32'd0);
            step();
        end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        check("to_last_busy_err", {31'd0, err}, 32'd0);
        step();
        check("to_resp_m0_ack", {31'd0, m0_ack}, 32'd1);
        check("to_resp_err", {31'd0, err}, 32'd1);
        check("to_resp_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 0;
        step();
        check("to_idle_err", {31'd0, err}, 32'd0);
        check("to_idle_m0_ack", {31'd0, m0_ack}, 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            check("hang_s_req", {31'd0, s_req}, 32'd1);
            check("hang_m0_ack", {31'd0, m0_ack}, 32'd0);
            check("hang_err", {31'd0, err}, 32'd0);
            step();
        end
        m0_req = 0;
        reset = 1;
        step();
        reset = 0;
        check("hang_recover_s_req", {31'd0, s_req}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
